// File: rtl/ascii_message_sequencer_if.sv
// Switch/character bus between the debounce stage, the message sequencer and the 7-segment decoder.
interface ascii_message_sequencer_if;
   logic       i_Switch;
   logic [7:0] o_Ascii_Value;
   logic       o_Busy;
   logic       o_Msg_Done;
   logic [3:0] o_Char_Index;

   modport master (
      output i_Switch,
      input  o_Ascii_Value, o_Busy, o_Msg_Done, o_Char_Index
   );

   modport slave (
      input  i_Switch,
      output o_Ascii_Value, o_Busy, o_Msg_Done, o_Char_Index
   );
endinterface

// File: rtl/ascii_message_sequencer.sv
// Steps through a stored ASCII message on switch presses, with a timed blank gap between characters.
// Optional hold-timer auto-advance is enabled by defining AUTO_ADVANCE_EN.
module ascii_message_sequencer #(
   parameter int                 MSG_LEN       = 5,
   parameter logic [8*MSG_LEN-1:0] MSG         = 40'h48454C4C4F,
   parameter int                 BLANK_CLKS    = 2_500_000,
   parameter int                 CLKS_PER_CHAR = 25_000_000
) (
   input logic                     i_Clk,
   input logic                     i_Rst,
   ascii_message_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

   localparam int                 GAP_W    = $clog2(BLANK_CLKS) + 1;
   localparam logic [GAP_W-1:0]   GAP_LAST = (BLANK_CLKS > 0) ? GAP_W'(BLANK_CLKS - 1) : '0;
   localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
   localparam logic [3:0]         LAST_IDX = 4'(MSG_LEN - 1);

   state_t           state_r, state_s;
   logic [3:0]       idx_r, idx_s;
   logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
   logic             switch_prev_r;
   logic             press_s, advance_s;
   logic [7:0]       ascii_r, ascii_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

`ifdef AUTO_ADVANCE_EN
   localparam int                HOLD_W    = $clog2(CLKS_PER_CHAR) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLKS_PER_CHAR - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
`endif

   // Character 0 lives in the most-significant byte of MSG.
   function automatic logic [7:0] msg_byte(input logic [3:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (idx == 4'(i)) b = MSG[8*(MSG_LEN-1-i) +: 8];
         else              b = b;
      end
      return b;
   endfunction

   assign press_s = bus.i_Switch & ~switch_prev_r;

   // Switch history keeps tracking the input through reset so a held switch never counts as a press.
   always_ff @(posedge i_Clk) begin
      switch_prev_r <= bus.i_Switch;
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_r   <= IDLE;
         idx_r     <= 4'd0;
         gap_cnt_r <= '0;
         ascii_r   <= 8'h00;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef AUTO_ADVANCE_EN
         hold_cnt_r <= '0;
`endif
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         gap_cnt_r <= gap_cnt_s;
         ascii_r   <= ascii_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
`ifdef AUTO_ADVANCE_EN
         hold_cnt_r <= hold_cnt_s;
`endif
      end
   end

   // Next state, next index and counter updates; counters clear on entry to their state.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
`ifdef AUTO_ADVANCE_EN
      advance_s = press_s | (hold_cnt_r == HOLD_LAST);
`else
      advance_s = press_s;
`endif
      case (state_r)
         IDLE: begin
            if (press_s) begin
               state_s = SHOW;
               idx_s   = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         SHOW: begin
            if (!advance_s) begin
               state_s = SHOW;
            end else if (idx_r == LAST_IDX) begin
               state_s = DONE;
            end else if (BLANK_CLKS > 0) begin
               state_s = GAP;
            end else begin
               state_s = SHOW;
               idx_s   = idx_r + 4'd1;
            end
         end
         GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               state_s = SHOW;
               idx_s   = idx_r + 4'd1;
            end else begin
               state_s = GAP;
            end
         end
         DONE: state_s = IDLE;
         default: begin
            state_s = IDLE;
            idx_s   = 4'd0;
         end
      endcase

      if (state_r == GAP && state_s == GAP) gap_cnt_s = gap_cnt_r + GAP_ONE;
      else                                  gap_cnt_s = '0;
`ifdef AUTO_ADVANCE_EN
      if (state_r == SHOW && state_s == SHOW && idx_s == idx_r) hold_cnt_s = hold_cnt_r + HOLD_ONE;
      else                                                      hold_cnt_s = '0;
`endif
   end

   // Output values for the upcoming state, registered alongside it.
   always_comb begin
      ascii_s = 8'h00;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_s)
         SHOW: begin
            ascii_s = msg_byte(idx_s);
            busy_s  = 1'b1;
         end
         GAP:  busy_s = 1'b1;
         DONE: done_s = 1'b1;
         IDLE: busy_s = 1'b0;
         default: busy_s = 1'b0;
      endcase
   end

   assign bus.o_Ascii_Value = ascii_r;
   assign bus.o_Busy        = busy_r;
   assign bus.o_Msg_Done    = done_r;
   assign bus.o_Char_Index  = idx_r;

endmodule

// File: tb/tb_ascii_message_sequencer.sv
// Directed bench for ascii_message_sequencer: reset, full HELLO playback, gap/press/reset corners, auto-advance.
module tb_ascii_message_sequencer;

   localparam int BLANK = 4;
   localparam int HOLD  = 10;

   typedef struct {
      logic       sw;
      logic [7:0] ascii;
      logic       busy;
      logic       done;
      logic [3:0] idx;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

   ascii_message_sequencer_if bus ();

   ascii_message_sequencer #(
      .MSG_LEN(5),
      .MSG(40'h48454C4C4F),
      .BLANK_CLKS(BLANK),
      .CLKS_PER_CHAR(HOLD)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input logic sw);
      bus.i_Switch = sw;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] a, input logic b,
                            input logic d, input logic [3:0] i);
      check({tag, " ascii"}, 32'(bus.o_Ascii_Value), 32'(a));
      check({tag, " busy"},  32'(bus.o_Busy),        32'(b));
      check({tag, " done"},  32'(bus.o_Msg_Done),    32'(d));
      check({tag, " index"}, 32'(bus.o_Char_Index),  32'(i));
   endtask

   function automatic void add(input logic sw, input logic [7:0] a, input logic b,
                               input logic d, input logic [3:0] i);
      vec_t v;
      v.sw = sw; v.ascii = a; v.busy = b; v.done = d; v.idx = i;
      vecs.push_back(v);
   endfunction

`ifdef AUTO_ADVANCE_EN
   int busy_cnt, first_4f, done_at, cnt_48, cnt_4c;
`endif

   initial begin
      // Full HELLO playback: each character shown two cycles, then a press into a 4-cycle gap.
      add(1'b1, 8'h48, 1'b1, 1'b0, 4'd0);
      add(1'b0, 8'h48, 1'b1, 1'b0, 4'd0);
      for (int c = 1; c < 5; c++) begin
         add(1'b1, 8'h00, 1'b1, 1'b0, 4'(c - 1));
         for (int g = 1; g < BLANK; g++) add(1'b0, 8'h00, 1'b1, 1'b0, 4'(c - 1));
         add(1'b0, hello[c], 1'b1, 1'b0, 4'(c));
         add(1'b0, hello[c], 1'b1, 1'b0, 4'(c));
      end
      add(1'b1, 8'h00, 1'b0, 1'b1, 4'd4);
      add(1'b0, 8'h00, 1'b0, 1'b0, 4'd4);
      add(1'b0, 8'h00, 1'b0, 1'b0, 4'd4);

      // Reset for three cycles.
      bus.i_Switch = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) tick(1'b0);
      check_out("reset", 8'h00, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;
      tick(1'b0);
      check_out("idle", 8'h00, 1'b0, 1'b0, 4'd0);

      foreach (vecs[n]) begin
         tick(vecs[n].sw);
         check_out($sformatf("vec%0d", n), vecs[n].ascii, vecs[n].busy, vecs[n].done, vecs[n].idx);
      end

      // Press two cycles into a gap is ignored; next character lands BLANK cycles after gap entry.
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      check_out("gap entry", 8'h00, 1'b1, 1'b0, 4'd0);
      tick(1'b0);
      tick(1'b1);
      check_out("gap press", 8'h00, 1'b1, 1'b0, 4'd0);
      tick(1'b0);
      check_out("gap late", 8'h00, 1'b1, 1'b0, 4'd0);
      tick(1'b0);
      check_out("gap exit", 8'h45, 1'b1, 1'b0, 4'd1);
      tick(1'b0);
      check_out("no queued", 8'h45, 1'b1, 1'b0, 4'd1);

      // Reset while "L" at index 2 is showing; reset also beats a simultaneous press.
      tick(1'b1);
      for (int g = 1; g < BLANK; g++) tick(1'b0);
      tick(1'b0);
      check_out("at L", 8'h4C, 1'b1, 1'b0, 4'd2);
      rst = 1'b1;
      tick(1'b1);
      check_out("mid reset", 8'h00, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;
      tick(1'b0);
      check_out("after reset", 8'h00, 1'b0, 1'b0, 4'd0);
      tick(1'b1);
      check_out("restart", 8'h48, 1'b1, 1'b0, 4'd0);

      // Switch held high across reset release does not start playback.
      rst = 1'b1;
      tick(1'b1);
      tick(1'b1);
      rst = 1'b0;
      tick(1'b1);
      tick(1'b1);
      check_out("held switch", 8'h00, 1'b0, 1'b0, 4'd0);
      tick(1'b0);
      tick(1'b1);
      check_out("low-high", 8'h48, 1'b1, 1'b0, 4'd0);

`ifdef AUTO_ADVANCE_EN
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      tick(1'b0);
      busy_cnt = 0; first_4f = -1; done_at = -1; cnt_48 = 0; cnt_4c = 0;
      tick(1'b1);
      for (int n = 0; n < 200; n++) begin
         if (bus.o_Busy) busy_cnt++;
         if (bus.o_Ascii_Value == 8'h48) cnt_48++;
         if (bus.o_Ascii_Value == 8'h4C) cnt_4c++;
         if (bus.o_Ascii_Value == 8'h4F && first_4f < 0) first_4f = n;
         if (bus.o_Msg_Done) begin
            done_at = n;
            break;
         end
         tick(1'b0);
      end
      check("auto done seen", 32'(done_at >= 0), 32'd1);
      check("auto done delay", 32'(done_at - first_4f), 32'(HOLD));
      check("auto busy cycles", 32'(busy_cnt), 32'(5 * HOLD + 4 * BLANK));
      check("auto H hold", 32'(cnt_48), 32'(HOLD));
      check("auto LL hold", 32'(cnt_4c), 32'(2 * HOLD));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
